// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one variable-latency memory between fetch and data ports.
// Data requests win ties. Optional ISSUE timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;

    // The counter must be able to hold TIMEOUT-1.
    if (TIMEOUT < 1 || 64'(TIMEOUT) >= (64'(1) << CNT_W)) begin : cfgCheck
        $error("mem_arbiter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    stateT       stateReg, stateNext;
    logic        ownerReg, ownerNext;   // 0 = fetch, 1 = data
    logic        memWeReg, memWeNext;
    logic [31:0] memAddrReg, memAddrNext;
    logic [31:0] memWdataReg, memWdataNext;
    logic [31:0] ifRdataReg, ifRdataNext;
    logic [31:0] dRdataReg, dRdataNext;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             errReg, errNext;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            ownerReg    <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            ifRdataReg  <= '0;
            dRdataReg   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cntReg      <= '0;
            errReg      <= 1'b0;
`endif
        end else begin
            stateReg    <= stateNext;
            ownerReg    <= ownerNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
            ifRdataReg  <= ifRdataNext;
            dRdataReg   <= dRdataNext;
`ifdef MEM_ARB_TIMEOUT_EN
            cntReg      <= cntNext;
            errReg      <= errNext;
`endif
        end
    end

    always_comb begin
        stateNext    = stateReg;
        ownerNext    = ownerReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        ifRdataNext  = ifRdataReg;
        dRdataNext   = dRdataReg;
`ifdef MEM_ARB_TIMEOUT_EN
        cntNext      = cntReg;
        errNext      = 1'b0;
`endif
        case (stateReg)
            IDLE: begin
                if (d_req) begin
                    ownerNext    = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    stateNext    = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
                    cntNext      = '0;
`endif
                end else if (if_req) begin
                    ownerNext    = 1'b0;
                    memWeNext    = 1'b0;
                    memAddrNext  = if_addr;
                    stateNext    = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
                    cntNext      = '0;
`endif
                end
            end
            ISSUE: begin
                // An ack in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    stateNext = RESP;
                    if (!memWeReg) begin
                        if (ownerReg) dRdataNext  = mem_rdata;
                        else          ifRdataNext = mem_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cntReg == TIMEOUT_LAST) begin
                    stateNext = RESP;
                    errNext   = 1'b1;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
`endif
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign mem_req   = (stateReg == ISSUE);
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign if_rdata  = ifRdataReg;
    assign d_rdata   = dRdataReg;
    assign if_ready  = (stateReg == RESP) && !ownerReg;
    assign d_ready   = (stateReg == RESP) && ownerReg;
    assign stall_f   = if_req & ~if_ready;
    assign stall_m   = d_req & ~d_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    assign err = errReg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a schedule/memory model computed from the arbitration rules.
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        stall_f, stall_m, mem_req, mem_we, mem_ack, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({mem_req, mem_we, if_ready, d_ready, err} !== 5'b0) begin
            nFails++;
            $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, if_ready, d_ready, err});
        end
        nChecks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            nFails++;
            $display("FAIL reset_bus: got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        nChecks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            nFails++;
            $display("FAIL reset_rdata: got if=%h d=%h required 0/0", if_rdata, d_rdata);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        nChecks++;
        if (mem_req !== 1'b0) begin
            nFails++;
            $display("FAIL reset_idle: got mem_req=%b required 0", mem_req);
        end
        $display("txn reset done");
    endtask

    task automatic test_fetch();
        logic [4:0] expReq   = 5'b00110;
        logic [4:0] expRdy   = 5'b01000;
        logic [4:0] expStall = 5'b00111;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h100; end
            if (c == 4) if_req = 1'b0;
            mem_ack   = (c == 2);
            mem_rdata = (c == 2) ? 32'hE3A00001 : 32'hDEADBEEF;
            @(negedge clk);
            nChecks++;
            if ({mem_req, if_ready, d_ready, stall_f} !== {expReq[c], expRdy[c], 1'b0, expStall[c]}) begin
                nFails++;
                $display("FAIL fetch_ctrl c%0d: got req/ifr/dr/stf=%b required %b", c,
                         {mem_req, if_ready, d_ready, stall_f}, {expReq[c], expRdy[c], 1'b0, expStall[c]});
            end
            if (expReq[c]) begin
                nChecks++;
                if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
                    nFails++;
                    $display("FAIL fetch_bus c%0d: got addr=%h we=%b required 00000100/0", c, mem_addr, mem_we);
                end
            end
            if (c == 3) begin
                nChecks++;
                if (if_rdata !== 32'hE3A00001) begin
                    nFails++;
                    $display("FAIL fetch_rdata: got %h required e3a00001", if_rdata);
                end
            end
        end
        $display("txn fetch addr=00000100 k=2");
    endtask

    task automatic test_store();
        logic [31:0] addrs [2];
        logic [31:0] wds   [2];
        logic [31:0] rds   [2];
        logic        wes   [2];
        addrs[0] = 32'h80; wds[0] = 32'h0;        rds[0] = 32'hCAFEF00D; wes[0] = 1'b0;
        addrs[1] = 32'h40; wds[1] = 32'h12345678; rds[1] = 32'h55AA55AA; wes[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (c == 0) begin
                    d_req = 1'b1; d_we = wes[t]; d_addr = addrs[t]; d_wdata = wds[t];
                end
                if (c == 3) d_req = 1'b0;
                mem_ack   = (c == 1);
                mem_rdata = rds[t];
                @(negedge clk);
                if (c == 0) begin
                    nChecks++;
                    if (mem_req !== 1'b0 || stall_m !== 1'b1) begin
                        nFails++;
                        $display("FAIL store_wait t%0d: got req=%b stall_m=%b required 0/1", t, mem_req, stall_m);
                    end
                end
                if (c == 1) begin
                    nChecks++;
                    if (mem_req !== 1'b1 || mem_we !== wes[t] || mem_addr !== addrs[t] ||
                        (wes[t] && mem_wdata !== wds[t])) begin
                        nFails++;
                        $display("FAIL store_bus t%0d: got req=%b we=%b addr=%h wdata=%h required 1/%b/%h/%h",
                                 t, mem_req, mem_we, mem_addr, mem_wdata, wes[t], addrs[t], wds[t]);
                    end
                end
                if (c == 2) begin
                    nChecks++;
                    if (d_ready !== 1'b1 || mem_req !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
                        nFails++;
                        $display("FAIL store_resp t%0d: got dr=%b req=%b d_rdata=%h required 1/0/cafef00d",
                                 t, d_ready, mem_req, d_rdata);
                    end
                end
            end
            $display("txn data we=%b addr=%h wdata=%h", wes[t], addrs[t], wds[t]);
        end
    endtask

    task automatic test_priority();
        logic [6:0] expReq   = 7'b0010010;
        logic [6:0] expDRdy  = 7'b0000100;
        logic [6:0] expIfRdy = 7'b0100000;
        logic [6:0] expStf   = 7'b0011111;
        logic [6:0] expStm   = 7'b0000011;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h104;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
            end
            if (c == 3) d_req = 1'b0;
            if (c == 6) if_req = 1'b0;
            mem_ack   = (c == 1) || (c == 4);
            mem_rdata = (c == 1) ? 32'h11111111 : 32'h22222222;
            @(negedge clk);
            nChecks++;
            if ({mem_req, d_ready, if_ready, stall_f, stall_m} !==
                {expReq[c], expDRdy[c], expIfRdy[c], expStf[c], expStm[c]}) begin
                nFails++;
                $display("FAIL prio_ctrl c%0d: got req/dr/ifr/stf/stm=%b required %b", c,
                         {mem_req, d_ready, if_ready, stall_f, stall_m},
                         {expReq[c], expDRdy[c], expIfRdy[c], expStf[c], expStm[c]});
            end
            if (c == 1 || c == 4) begin
                nChecks++;
                if (mem_addr !== ((c == 1) ? 32'h200 : 32'h104)) begin
                    nFails++;
                    $display("FAIL prio_addr c%0d: got %h required %h", c, mem_addr,
                             (c == 1) ? 32'h200 : 32'h104);
                end
            end
            if (c == 5) begin
                nChecks++;
                if (d_rdata !== 32'h11111111 || if_rdata !== 32'h22222222) begin
                    nFails++;
                    $display("FAIL prio_rdata: got d=%h if=%h required 11111111/22222222", d_rdata, if_rdata);
                end
            end
        end
        $display("txn data-then-fetch d_addr=00000200 if_addr=00000104");
    endtask

    task automatic test_spurious_ack();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mem_ack   = (c == 0);
            mem_rdata = 32'hBADBAD00;
            @(negedge clk);
            nChecks++;
            if ({mem_req, if_ready, d_ready} !== 3'b000) begin
                nFails++;
                $display("FAIL spurious_ctrl c%0d: got %b required 000", c, {mem_req, if_ready, d_ready});
            end
        end
        nChecks++;
        if (if_rdata !== 32'h22222222 || d_rdata !== 32'h11111111) begin
            nFails++;
            $display("FAIL spurious_rdata: got if=%h d=%h required 22222222/11111111", if_rdata, d_rdata);
        end
        $display("txn spurious ack in idle");
    endtask

    task automatic test_reset_abort();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h300; end
            if (c == 2) begin
                reset = 1'b0; if_req = 1'b0;
                #1;
                nChecks++;
                if (mem_req !== 1'b0) begin
                    nFails++;
                    $display("FAIL abort_drop: got mem_req=%b required 0", mem_req);
                end
            end
            if (c == 3) reset = 1'b1;
            mem_ack   = (c == 4);
            mem_rdata = 32'h77777777;
            @(negedge clk);
            if (c == 1) begin
                nChecks++;
                if (mem_req !== 1'b1) begin
                    nFails++;
                    $display("FAIL abort_issue: got mem_req=%b required 1", mem_req);
                end
            end
            if (c >= 2) begin
                nChecks++;
                if ({mem_req, if_ready, d_ready} !== 3'b000) begin
                    nFails++;
                    $display("FAIL abort_ctrl c%0d: got %b required 000", c, {mem_req, if_ready, d_ready});
                end
            end
        end
        nChecks++;
        if (if_rdata !== 32'h0) begin
            nFails++;
            $display("FAIL abort_rdata: got %h required 0", if_rdata);
        end
        $display("txn fetch aborted by reset");
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic eReq, eRdy, eErr;
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 7; c++) begin
                @(posedge clk); #1;
                if (c == 0) begin if_req = 1'b1; if_addr = 32'h400; end
                if (c == 6) if_req = 1'b0;
                mem_ack   = (t == 1) && (c == 4);
                mem_rdata = 32'h99999999;
                @(negedge clk);
                eReq = (c >= 1) && (c <= 4);
                eRdy = (c == 5);
                eErr = (t == 0) && (c == 5);
                nChecks++;
                if ({mem_req, if_ready, err} !== {eReq, eRdy, eErr}) begin
                    nFails++;
                    $display("FAIL timeout_ctrl t%0d c%0d: got req/ifr/err=%b required %b", t, c,
                             {mem_req, if_ready, err}, {eReq, eRdy, eErr});
                end
                if (c == 5) begin
                    nChecks++;
                    if (if_rdata !== ((t == 0) ? 32'h0 : 32'h99999999)) begin
                        nFails++;
                        $display("FAIL timeout_rdata t%0d: got %h required %h", t, if_rdata,
                                 (t == 0) ? 32'h0 : 32'h99999999);
                    end
                end
            end
            $display("txn fetch timeout case %0d", t);
        end
    endtask
`endif

    task automatic test_random(input int iters);
        logic [31:0] refMem [logic [31:0]];
        logic [31:0] expIf, expD, fAddr, dAddr, dWd, expAddr, expWd;
        logic        dWe, doF, doD, expReq, expIfRdy, expDRdy, expWe;
        int          n, endC;
        int          gPort [2];
        int          gStart[2];
        int          gK    [2];
        logic [31:0] gAddr [2];
        logic [31:0] gWd   [2];
        logic [31:0] gRet  [2];
        logic        gWe   [2];
        // Fresh reset so the held read data starts from zero.
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        expIf = 32'h0;
        expD  = 32'h0;
        for (int it = 0; it < iters; it++) begin
            doF   = 1'($urandom_range(0, 1));
            doD   = 1'($urandom_range(0, 1));
            if (!doF && !doD) doD = 1'b1;
            fAddr = 32'($urandom_range(0, 15)) << 2;
            dAddr = 32'($urandom_range(0, 15)) << 2;
            dWe   = 1'($urandom_range(0, 1));
            dWd   = $urandom;
            n = 0;
            if (doD) begin gPort[n] = 1; gAddr[n] = dAddr; gWe[n] = dWe; gWd[n] = dWd; n++; end
            if (doF) begin gPort[n] = 0; gAddr[n] = fAddr; gWe[n] = 1'b0; gWd[n] = 32'h0; n++; end
            for (int i = 0; i < n; i++) begin
                gK[i]     = int'($urandom_range(1, 4));
                gStart[i] = (i == 0) ? 1 : gStart[i-1] + gK[i-1] + 2;
                gRet[i]   = 32'h0;
            end
            endC = gStart[n-1] + gK[n-1] + 1;
            for (int c = 0; c <= endC; c++) begin
                @(posedge clk); #1;
                if (c == 0) begin
                    if_req = doF; if_addr = fAddr;
                    d_req = doD; d_we = dWe; d_addr = dAddr; d_wdata = dWd;
                end
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                expReq = 1'b0; expIfRdy = 1'b0; expDRdy = 1'b0;
                expAddr = 32'h0; expWe = 1'b0; expWd = 32'h0;
                for (int i = 0; i < n; i++) begin
                    if (c == gStart[i] + gK[i] + 1) begin
                        if (gPort[i] == 1) d_req = 1'b0;
                        else               if_req = 1'b0;
                    end
                    if (c == gStart[i] + gK[i] - 1) begin
                        mem_ack = 1'b1;
                        if (gWe[i]) refMem[gAddr[i]] = gWd[i];
                        else begin
                            gRet[i]   = refMem.exists(gAddr[i]) ? refMem[gAddr[i]] : ~gAddr[i];
                            mem_rdata = gRet[i];
                        end
                    end
                    if (c >= gStart[i] && c < gStart[i] + gK[i]) begin
                        expReq = 1'b1; expAddr = gAddr[i]; expWe = gWe[i]; expWd = gWd[i];
                    end
                    if (c == gStart[i] + gK[i]) begin
                        if (gPort[i] == 1) begin
                            expDRdy = 1'b1;
                            if (!gWe[i]) expD = gRet[i];
                        end else begin
                            expIfRdy = 1'b1;
                            expIf    = gRet[i];
                        end
                    end
                end
                @(negedge clk);
                nChecks++;
                if ({mem_req, if_ready, d_ready, err} !== {expReq, expIfRdy, expDRdy, 1'b0}) begin
                    nFails++;
                    $display("FAIL rand_ctrl it%0d c%0d: got req/ifr/dr/err=%b required %b", it, c,
                             {mem_req, if_ready, d_ready, err}, {expReq, expIfRdy, expDRdy, 1'b0});
                end
                if (expReq) begin
                    nChecks++;
                    if (mem_addr !== expAddr || mem_we !== expWe || (expWe && mem_wdata !== expWd)) begin
                        nFails++;
                        $display("FAIL rand_bus it%0d c%0d: got addr=%h we=%b wdata=%h required %h/%b/%h",
                                 it, c, mem_addr, mem_we, mem_wdata, expAddr, expWe, expWd);
                    end
                end
                nChecks++;
                if (if_rdata !== expIf || d_rdata !== expD) begin
                    nFails++;
                    $display("FAIL rand_rdata it%0d c%0d: got if=%h d=%h required %h/%h",
                             it, c, if_rdata, d_rdata, expIf, expD);
                end
                nChecks++;
                if ({stall_f, stall_m} !== {if_req & ~expIfRdy, d_req & ~expDRdy}) begin
                    nFails++;
                    $display("FAIL rand_stall it%0d c%0d: got %b required %b", it, c,
                             {stall_f, stall_m}, {if_req & ~expIfRdy, d_req & ~expDRdy});
                end
            end
            $display("txn rand %0d fetch=%0d(%h) data=%0d we=%0d (%h) grants=%0d",
                     it, doF, fAddr, doD, dWe, dAddr, n);
        end
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_spurious_ack();
        test_reset_abort();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
